// File: rtl/seg_rr_sched.sv
// Round-robin scheduler that time-shares one 3-bit-code-to-7-line decoder among four requesters.
// Each grant shows the latched code for DWELL cycles, then pulses ack for the granted channel.
module seg_rr_sched #(
  parameter int DWELL = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  req_i,
  input  logic [11:0] code_i,
  output logic [6:0]  seg_o,
  output logic [3:0]  gnt_o,
  output logic [3:0]  ack_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ACK  = 2'd2
  } state_e;

  // DWELL is meant to stay within 1..255 so the reload fits the 8-bit counter.
  localparam logic [7:0] DwellReload = 8'(DWELL - 1);

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  ack_q, ack_d;
  logic [6:0]  seg_q, seg_d;
  logic        busy_q, busy_d;

  logic        winValid;
  logic [1:0]  winIdx;
  logic [2:0]  winCode;
  logic [1:0]  gntIdx;

  function automatic logic [6:0] decode(input logic [2:0] k);
    logic [6:0] pat;
    pat = 7'd0;
    case (k)
      3'd1: pat = 7'b0000001;
      3'd2: pat = 7'b0000010;
      3'd3: pat = 7'b0000100;
      3'd4: pat = 7'b0001000;
      3'd5: pat = 7'b0010000;
      3'd6: pat = 7'b0100000;
      3'd7: pat = 7'b1000000;
      default: pat = 7'd0;
    endcase
    return pat;
  endfunction

  // Search ptr+1, ptr+2, ptr+3, ptr; the 2-bit sum wraps so i=4 lands on ptr itself.
  always_comb begin
    winValid = 1'b0;
    winIdx   = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      if (!winValid && req_i[ptr_q + 2'(i)]) begin
        winValid = 1'b1;
        winIdx   = ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    winCode = code_i[2:0];
    case (winIdx)
      2'd0: winCode = code_i[2:0];
      2'd1: winCode = code_i[5:3];
      2'd2: winCode = code_i[8:6];
      2'd3: winCode = code_i[11:9];
      default: winCode = code_i[2:0];
    endcase
  end

  always_comb begin
    gntIdx = 2'd0;
    case (gnt_q)
      4'b0010: gntIdx = 2'd1;
      4'b0100: gntIdx = 2'd2;
      4'b1000: gntIdx = 2'd3;
      default: gntIdx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    seg_d   = seg_q;
    ack_d   = 4'd0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        gnt_d  = 4'd0;
        seg_d  = 7'd0;
        busy_d = 1'b0;
        if (winValid) begin
          code_d  = winCode;
          gnt_d   = 4'b0001 << winIdx;
          seg_d   = decode(winCode);
          cnt_d   = DwellReload;
          busy_d  = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        busy_d = 1'b1;
        seg_d  = decode(code_q);
        if (cnt_q == 8'd0) begin
          ack_d   = gnt_q;
          gnt_d   = 4'd0;
          seg_d   = 7'd0;
          ptr_d   = gntIdx;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK: begin
        gnt_d   = 4'd0;
        seg_d   = 7'd0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 4'd0;
        seg_d   = 7'd0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Pointer resets to 3 so channel 0 wins the first arbitration after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      code_q  <= 3'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'd0;
      ack_q   <= 4'd0;
      seg_q   <= 7'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
    end
  end

  assign seg_o  = seg_q;
  assign gnt_o  = gnt_q;
  assign ack_o  = ack_q;
  assign busy_o = busy_q;

endmodule
